riscv_dmem_responder: RTL and testbench
=======================================

// Module: riscv_dmem_responder
// PURPOSE
//  Responder for the core's data-memory interface (data_addr/data_wdata/data_we in, data_rdata out).
//  Decodes each access to word RAM or a small MMIO block: cycle counter, tohost, console byte FIFO.
//  The console FIFO drains off-chip over a valid/ready port.
//  Sits beside the core in the top level; the core samples data_rdata in the same cycle it drives data_addr.
// PARAMETERS
//  DATA_WIDTH   32            bus width; only 32 supported
//  DEPTH_WORDS  1024          RAM words; power of 2; RAM occupies bytes [0, DEPTH_WORDS*4)
//  MMIO_BASE    32'h8000_0000 base of 16-byte MMIO window; must not overlap RAM
//  FIFO_DEPTH   4             console FIFO entries; power of 2, >=2
// PORTS
//  clk          in   1   single clock, all state on posedge
//  reset_n      in   1   asynchronous, active-low reset
//  data_addr    in   32  byte address from core; bits [1:0] ignored (word access only)
//  data_wdata   in   32  store data
//  data_we      in   1   store strobe, qualifies data_addr/data_wdata this cycle
//  data_rdata   out  32  load data, combinational from data_addr
//  cons_data    out  8   console byte at FIFO head
//  cons_valid   out  1   FIFO not empty
//  cons_ready   in   1   sink accepts cons_data when cons_valid & cons_ready at posedge
//  tohost_valid out  1   sticky: TOHOST has been written
//  tohost_data  out  32  last value written to TOHOST
//  bus_err      out  1   sticky: store to unmapped address or console overflow
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset (reset_n=0): cycle counter, FIFO pointers/count, tohost_valid, tohost_data, bus_err and overflow all 0.
//   cons_valid=0. RAM contents are not reset and persist across reset.
//  Decode on word address: RAM if addr < DEPTH_WORDS*4; MMIO if addr[31:4]==MMIO_BASE[31:4]; else unmapped.
//  Reads: no side effects, combinational. Store at the same address in the same cycle -> old value; next cycle -> new value.
//   RAM: mem[addr[log2(DEPTH_WORDS)+1:2]].
//   +0x0 CONSOLE: {28'b0, overflow, full, empty, 1'b0}.
//   +0x4 CYCLE: free-running 32-bit counter, +1 every cycle out of reset, wraps 0xFFFF_FFFF->0.
//   +0x8 TOHOST: tohost_data.
//   +0xC STATUS: {bus_err, 26'b0, fifo_count[4:0]}.
//   Unmapped: returns 0.
//  Writes take effect at the posedge where data_we=1:
//   RAM: full-word write.
//   CONSOLE: push data_wdata[7:0].
//   CYCLE: write ignored.
//   TOHOST: tohost_data<=wdata, tohost_valid<=1; rewriting updates data, valid stays 1.
//   STATUS: write 1 to bit31 clears bus_err and overflow.
//   Unmapped: no state change except bus_err<=1.
//  Console FIFO:
//   Pop when cons_valid & cons_ready.
//   Push when full with no pop in the same cycle: byte dropped, overflow<=1, bus_err<=1.
//   Push when full with a pop in the same cycle: push accepted, count unchanged.
//   Push and pop on empty FIFO: byte is written; cons_valid rises next cycle (no bypass).
//   cons_data is stable while cons_valid & !cons_ready.
//   Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
//   If a STATUS clear and a new error happen in the same cycle, the error wins (flag ends 1).
//  Reset asserted mid-operation: FIFO is flushed immediately; any pending byte is lost; cons_valid drops asynchronously.
// STRUCTURE
//  Shared package riscv_pkg:
//   MMIO offset localparams CONS_OFS=4'h0, CYCLE_OFS=4'h4, TOHOST_OFS=4'h8, STATUS_OFS=4'hC.
//   Region enum {REG_RAM, REG_MMIO, REG_UNMAPPED}.
//  One sub-module, cons_fifo (params WIDTH, DEPTH; push/pop/full/empty/count).
//  Decode, RAM, counter and flags stay in this module.
// TESTING
//  1 Store 0xDEAD_BEEF @0x10, next cycle read 0x10 -> 0xDEAD_BEEF; read 0x12 -> same word.
//  2 cons_ready=0; store 0x41,0x42,0x43 to MMIO+0 -> STATUS count=3.
//    Then cons_ready=1 -> cons_data 0x41,0x42,0x43 on consecutive cycles; then cons_valid=0, empty=1.
//  3 cons_ready=0; 5 pushes with FIFO_DEPTH=4 -> 5th dropped, overflow=1, bus_err=1.
//    Store 0x8000_0000 to STATUS -> both 0 next cycle.
//  4 Store 0x1 to TOHOST -> next cycle tohost_valid=1, tohost_data=1. Reads of CYCLE 3 cycles apart differ by exactly 3.
//  5 Store to 0x4000_0000 -> bus_err=1, RAM unchanged. Load from it -> 0.
//    Full FIFO push with simultaneous pop -> count stays 4, no overflow.
//  6 reset_n low mid-drain with 2 bytes queued -> cons_valid=0, CYCLE=0, tohost_valid=0 immediately.
//    RAM word @0x10 still 0xDEAD_BEEF after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory responder: MMIO register offsets,
// the address-region type and the address decoder.
package riscv_pkg;

    localparam logic [3:0] CONS_OFS   = 4'h0;
    localparam logic [3:0] CYCLE_OFS  = 4'h4;
    localparam logic [3:0] TOHOST_OFS = 4'h8;
    localparam logic [3:0] STATUS_OFS = 4'hC;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_UNMAPPED
    } region_t;

    // RAM wins first; the MMIO window is matched on the 16-byte-aligned upper bits.
    function automatic region_t decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes,
                                              input logic [31:0] mmio_base);
        if (addr < ram_bytes)
            return REG_RAM;
        else if (addr[31:4] == mmio_base[31:4])
            return REG_MMIO;
        else
            return REG_UNMAPPED;
    endfunction

endpackage

// File: rtl/cons_fifo.sv
// Console byte FIFO. A push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle; otherwise the byte is dropped and the
// caller is expected to flag the overflow. Pointers and count clear
// asynchronously; the storage array is never reset.
module cons_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign pop_ok    = pop & ~empty;
    assign push_ok   = push & (~full | pop_ok);
    assign head_data = store[rd_ptr];

    // Pointer and occupancy bookkeeping; power-of-2 depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)
                count <= count + 1'b1;
            else if (pop_ok && !push_ok)
                count <= count - 1'b1;
        end
    end

    // Byte storage, written only for accepted pushes.
    always_ff @(posedge clk) begin
        if (push_ok)
            store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder beside the core: word RAM plus a 16-byte MMIO block
// (console FIFO, free-running cycle counter, tohost mailbox, status/error).
// Loads are combinational from data_addr; stores commit at the clock edge.
module riscv_dmem_responder
    import riscv_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    input  logic                  data_we,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic [7:0]            cons_data,
    output logic                  cons_valid,
    input  logic                  cons_ready,
    output logic                  tohost_valid,
    output logic [DATA_WIDTH-1:0] tohost_data,
    output logic                  bus_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   cycle_count;
    logic          overflow;
    region_t       region;
    logic [3:0]    ofs;
    logic          mmio_we;
    logic          cons_push;
    logic          cons_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [4:0]    count5;
    logic          ovf_event;
    logic          err_event;
    logic          err_clear;

    assign region     = decode_region(data_addr, RAM_BYTES, MMIO_BASE);
    assign ofs        = {data_addr[3:2], 2'b00};
    assign mmio_we    = data_we && (region == REG_MMIO);
    assign cons_push  = mmio_we && (ofs == CONS_OFS);
    assign cons_valid = ~fifo_empty;
    assign cons_pop   = cons_valid & cons_ready;
    assign count5     = 5'(fifo_count);

    // A push that finds the FIFO full with nothing leaving is dropped.
    assign ovf_event  = cons_push && fifo_full && !cons_pop;
    assign err_event  = ovf_event || (data_we && (region == REG_UNMAPPED));
    assign err_clear  = mmio_we && (ofs == STATUS_OFS) && data_wdata[31];

    cons_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_cons_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (cons_push),
        .push_data (data_wdata[7:0]),
        .pop       (cons_pop),
        .head_data (cons_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Word RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (data_we && region == REG_RAM)
            mem[data_addr[AW+1:2]] <= data_wdata;
    end

    // Free-running cycle counter; stores to it are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cycle_count <= '0;
        else
            cycle_count <= cycle_count + 32'd1;
    end

    // Tohost mailbox: valid is sticky once any value has been written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tohost_valid <= 1'b0;
            tohost_data  <= '0;
        end else if (mmio_we && ofs == TOHOST_OFS) begin
            tohost_valid <= 1'b1;
            tohost_data  <= data_wdata;
        end
    end

    // Sticky error flags; a new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_err  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (err_event)
                bus_err <= 1'b1;
            else if (err_clear)
                bus_err <= 1'b0;
            if (ovf_event)
                overflow <= 1'b1;
            else if (err_clear)
                overflow <= 1'b0;
        end
    end

    // Side-effect-free load mux.
    always_comb begin
        data_rdata = '0;
        case (region)
            REG_RAM:  data_rdata = mem[data_addr[AW+1:2]];
            REG_MMIO: begin
                case (ofs)
                    CONS_OFS:   data_rdata = {28'b0, overflow, fifo_full, fifo_empty, 1'b0};
                    CYCLE_OFS:  data_rdata = cycle_count;
                    TOHOST_OFS: data_rdata = tohost_data;
                    STATUS_OFS: data_rdata = {bus_err, 26'b0, count5};
                    default:    data_rdata = '0;
                endcase
            end
            default:  data_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Self-checking bench for riscv_dmem_responder: directed scenarios followed
// by randomized traffic, all compared against a queue/array reference model.
module tb_riscv_dmem_responder;

    localparam logic [31:0] MMIO = 32'h8000_0000;
    localparam int          NWORDS = 1024;
    localparam int          FDEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_we;
    logic [31:0] data_rdata;
    logic [7:0]  cons_data;
    logic        cons_valid;
    logic        cons_ready;
    logic        tohost_valid;
    logic [31:0] tohost_data;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] ram_m   [NWORDS];
    bit          known_m [NWORDS];
    logic [7:0]  q_m[$];
    logic [31:0] cyc_m;
    logic [31:0] toh_d_m;
    bit          toh_v_m;
    bit          err_m;
    bit          ovf_m;

    logic [31:0] last_rdata;
    logic [7:0]  last_cons;
    logic [31:0] cyc_a;

    riscv_dmem_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_we      (data_we),
        .data_rdata   (data_rdata),
        .cons_data    (cons_data),
        .cons_valid   (cons_valid),
        .cons_ready   (cons_ready),
        .tohost_valid (tohost_valid),
        .tohost_data  (tohost_data),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int region_of(input logic [31:0] addr);
        if (addr < NWORDS * 4) return 0;
        if ((addr >> 4) == (MMIO >> 4)) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr, output bit known);
        int r;
        int w;
        known = 1;
        r = region_of(addr);
        if (r == 0) begin
            w = int'(addr / 4);
            known = known_m[w];
            return ram_m[w];
        end
        if (r == 2) return 0;
        case ((addr % 16) / 4)
            0: return (32'(ovf_m) * 8) + (32'(q_m.size() == FDEPTH) * 4) + (32'(q_m.size() == 0) * 2);
            1: return cyc_m;
            2: return toh_d_m;
            default: return (32'(err_m) << 31) + 32'(q_m.size());
        endcase
    endfunction

    task automatic model_reset();
        q_m.delete();
        cyc_m = 0; toh_d_m = 0; toh_v_m = 0; err_m = 0; ovf_m = 0;
    endtask

    task automatic model_update(input bit we, input logic [31:0] addr, input logic [31:0] wd, input bit rdy);
        bit pop, was_full, ovf_ev, err_ev, clr;
        int r;
        int ofs;
        r = region_of(addr);
        ofs = int'((addr % 16) / 4);
        pop = (q_m.size() > 0) && rdy;
        was_full = (q_m.size() == FDEPTH);
        ovf_ev = 0; err_ev = 0; clr = 0;
        if (pop) void'(q_m.pop_front());
        if (we) begin
            if (r == 0) begin
                ram_m[addr / 4] = wd;
                known_m[addr / 4] = 1;
            end else if (r == 2) begin
                err_ev = 1;
            end else begin
                case (ofs)
                    0: if (!was_full || pop) q_m.push_back(wd[7:0]); else ovf_ev = 1;
                    2: begin toh_d_m = wd; toh_v_m = 1; end
                    3: clr = wd[31];
                    default: ;
                endcase
            end
        end
        if (ovf_ev || err_ev) err_m = 1; else if (clr) err_m = 0;
        if (ovf_ev) ovf_m = 1; else if (clr) ovf_m = 0;
        cyc_m = cyc_m + 1;
    endtask

    // One bus cycle: drive, compare outputs against the model, advance both.
    task automatic step(input bit we, input logic [31:0] addr, input logic [31:0] wd, input bit rdy);
        logic [31:0] exp;
        bit known;
        data_we = we; data_addr = addr; data_wdata = wd; cons_ready = rdy;
        #1;
        last_rdata = data_rdata;
        last_cons  = cons_data;
        exp = model_read(addr, known);
        if (known) check_eq("rdata", data_rdata, exp);
        check_eq("cons_valid", 32'(cons_valid), 32'(q_m.size() > 0));
        if (q_m.size() > 0) check_eq("cons_data", 32'(cons_data), 32'(q_m[0]));
        check_eq("tohost_valid", 32'(tohost_valid), 32'(toh_v_m));
        check_eq("tohost_data", tohost_data, toh_d_m);
        check_eq("bus_err", 32'(bus_err), 32'(err_m));
        model_update(we, addr, wd, rdy);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        int idx;
        sel = $urandom_range(0, 9);
        if (sel <= 3) begin
            idx = ($urandom_range(0, 16) == 16) ? NWORDS - 1 : $urandom_range(0, 15);
            return 32'(idx * 4 + $urandom_range(0, 3));
        end
        if (sel <= 7) return MMIO + 32'($urandom_range(0, 15));
        if (sel == 8) return 32'h1000 + 32'($urandom_range(0, 3) * 4);
        return ($urandom_range(0, 1) == 1) ? (32'h4000_0000 | 32'($urandom_range(0, 255))) : MMIO + 32'h10;
    endfunction

    initial begin
        for (int i = 0; i < NWORDS; i++) known_m[i] = 0;
        model_reset();
        reset_n = 1'b0; data_we = 0; data_addr = 0; data_wdata = 0; cons_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        data_addr = MMIO + 32'h4;
        #1;
        check_eq("rst_cycle", data_rdata, 32'h0);
        check_eq("rst_cons_valid", 32'(cons_valid), 32'h0);
        check_eq("rst_tohost_valid", 32'(tohost_valid), 32'h0);
        check_eq("rst_bus_err", 32'(bus_err), 32'h0);
        data_addr = MMIO + 32'hC;
        #1;
        check_eq("rst_status", data_rdata, 32'h0);
        reset_n = 1'b1;

        // Give the random phase a populated RAM region, including the top word.
        for (int i = 0; i < 16; i++) step(1, 32'(i * 4), $urandom, 0);
        step(1, 32'((NWORDS - 1) * 4), $urandom, 0);

        // 1: store then load, byte offset ignored
        step(1, 32'h10, 32'hDEAD_BEEF, 0);
        step(0, 32'h10, 0, 0);
        check_eq("t1_rd10", last_rdata, 32'hDEAD_BEEF);
        step(0, 32'h12, 0, 0);
        check_eq("t1_rd12", last_rdata, 32'hDEAD_BEEF);

        // 2: queue three bytes, then drain
        step(1, MMIO, 32'h41, 0);
        step(1, MMIO, 32'h42, 0);
        step(1, MMIO, 32'h43, 0);
        step(0, MMIO + 32'hC, 0, 0);
        check_eq("t2_count", last_rdata & 32'h1F, 32'd3);
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 0, 1);
            check_eq("t2_drain", 32'(last_cons), 32'h41 + 32'(i));
        end
        step(0, MMIO, 0, 1);
        check_eq("t2_valid_low", 32'(cons_valid), 32'h0);
        check_eq("t2_empty", (last_rdata >> 1) & 32'h1, 32'h1);

        // 3: overflow on fifth push, then clear via STATUS
        for (int i = 0; i < 5; i++) step(1, MMIO, 32'h60 + 32'(i), 0);
        step(0, MMIO, 0, 0);
        check_eq("t3_overflow", (last_rdata >> 3) & 32'h1, 32'h1);
        check_eq("t3_bus_err", 32'(bus_err), 32'h1);
        step(1, MMIO + 32'hC, 32'h8000_0000, 0);
        step(0, MMIO + 32'hC, 0, 0);
        check_eq("t3_cleared", last_rdata, 32'd4);

        // 5b: push into full FIFO with simultaneous pop
        step(1, MMIO, 32'h77, 1);
        step(0, MMIO + 32'hC, 0, 0);
        check_eq("t5_count4", last_rdata, 32'd4);

        // 4: tohost and cycle counter spacing
        step(1, MMIO + 32'h8, 32'h1, 0);
        check_eq("t4_tohost_valid", 32'(tohost_valid), 32'h1);
        check_eq("t4_tohost_data", tohost_data, 32'h1);
        step(0, MMIO + 32'h4, 0, 0);
        cyc_a = last_rdata;
        step(0, 32'h0, 0, 0);
        step(0, 32'h0, 0, 0);
        step(0, MMIO + 32'h4, 0, 0);
        check_eq("t4_cycle_delta", last_rdata - cyc_a, 32'd3);

        // 5: unmapped store and load
        step(0, 32'h0, 0, 0);
        cyc_a = last_rdata;
        step(1, 32'h4000_0000, 32'h1234_5678, 0);
        check_eq("t5_bus_err", 32'(bus_err), 32'h1);
        step(0, 32'h4000_0000, 0, 0);
        check_eq("t5_unmapped_rd", last_rdata, 32'h0);
        step(0, 32'h0, 0, 0);
        check_eq("t5_ram_intact", last_rdata, cyc_a);

        // 6: reset mid-drain with two bytes queued
        for (int i = 0; i < 4; i++) step(0, 32'h0, 0, 1);
        step(1, MMIO, 32'h31, 0);
        step(1, MMIO, 32'h32, 0);
        step(0, 32'h0, 0, 1);
        reset_n = 1'b0;
        data_we = 0; data_addr = MMIO + 32'h4;
        #1;
        check_eq("t6_cons_valid", 32'(cons_valid), 32'h0);
        check_eq("t6_cycle", data_rdata, 32'h0);
        check_eq("t6_tohost_valid", 32'(tohost_valid), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(0, 32'h10, 0, 0);
        check_eq("t6_ram_kept", last_rdata, 32'hDEAD_BEEF);

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
